// File: rtl/systola_pkg.sv
// systola_pkg: shared word type, pointer-width helper and pad-counter width for the systolic column buffers
package systola_pkg;
  localparam int WIDTH = 8;
  localparam int PAD_CNT_W = 8;
  typedef logic [WIDTH-1:0] word_t;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/outbuf_deskew_if.sv
// outbuf_deskew_if: column-drain bus between the PE column, the deskew buffer and the result reader (ovf present when OUTBUF_OVF_FLAG_EN is defined)
interface outbuf_deskew_if #(parameter int WIDTH = 8);
  logic             start;
  logic             write;
  logic [WIDTH-1:0] din;
  logic             read;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic             dvalid;
`ifdef OUTBUF_OVF_FLAG_EN
  logic             ovf;
  modport master (output start, write, din, read, input dout, empty, full, dvalid, ovf);
  modport slave  (input start, write, din, read, output dout, empty, full, dvalid, ovf);
`else
  modport master (output start, write, din, read, input dout, empty, full, dvalid);
  modport slave  (input start, write, din, read, output dout, empty, full, dvalid);
`endif
endinterface

// File: rtl/outbuf_deskew_mem.sv
// outbuf_mem: DEPTH x WIDTH register array with one synchronous write port and one registered read port
module outbuf_mem
  import systola_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_i,
  input  logic [ptr_w(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]        wdata_i,
  input  logic                    re_i,
  input  logic [ptr_w(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]        rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  // storage array needs no reset: occupancy lives in the controller's count
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  // read register holds between accepted reads and clears on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/outbuf_deskew.sv
// outbuf_deskew: drops the leading PADDING words of each run and FIFOs the rest with one-cycle read latency (optional sticky ovf via OUTBUF_OVF_FLAG_EN)
module outbuf_deskew
  import systola_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int PADDING = 0
) (
  input logic              clk,
  input logic              rst,
  outbuf_deskew_if.slave   bus
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PAD_CNT_W-1:0] PAD = PAD_CNT_W'(PADDING);
  logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PAD_CNT_W-1:0] dcnt_q, dcnt_d;
  logic                 empty_q, full_q, dvalid_q;
  logic                 discard, is_empty, is_full, rd_go, wr_go, wr_drop;
  logic [WIDTH-1:0]     rdata;
  // accept/discard decisions and next-state; start overrides everything in its cycle
  always_comb begin
    is_empty = cnt_q == '0;
    is_full  = cnt_q == CW'(DEPTH);
    discard  = dcnt_q != PAD;
    rd_go    = bus.read & ~bus.start & ~is_empty;
    wr_go    = bus.write & ~bus.start & ~discard & (~is_full | rd_go);
    wr_drop  = bus.write & ~bus.start & ~discard & is_full & ~bus.read;
    wptr_d   = bus.start ? '0 : wptr_q + PW'(wr_go);
    rptr_d   = bus.start ? '0 : rptr_q + PW'(rd_go);
    cnt_d    = bus.start ? '0 : cnt_q + CW'(wr_go) - CW'(rd_go);
    dcnt_d   = bus.start ? '0 : dcnt_q + PAD_CNT_W'(bus.write & discard);
  end
  // control state; flags are registered from the next count so outputs have no input path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      dcnt_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      dvalid_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      dcnt_q   <= dcnt_d;
      empty_q  <= cnt_d == '0;
      full_q   <= cnt_d == CW'(DEPTH);
      dvalid_q <= rd_go;
    end
  end
  outbuf_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_go),
    .waddr_i (wptr_q),
    .wdata_i (bus.din),
    .re_i    (rd_go),
    .raddr_i (rptr_q),
    .rdata_o (rdata)
  );
  assign bus.dout   = rdata;
  assign bus.empty  = empty_q;
  assign bus.full   = full_q;
  assign bus.dvalid = dvalid_q;
`ifdef OUTBUF_OVF_FLAG_EN
  logic ovf_q;
  // sticky overflow: set on a write dropped while full, cleared only by reset or start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else ovf_q <= bus.start ? 1'b0 : ovf_q | wr_drop;
  end
  assign bus.ovf = ovf_q;
`else
  logic unused_drop;
  assign unused_drop = wr_drop;
`endif
endmodule

// File: tb/tb_outbuf_deskew.sv
// tb_outbuf_deskew: directed checks of discard, FIFO order, full/empty corners, start and async reset
module tb_outbuf_deskew;
  import systola_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  outbuf_deskew_if #(.WIDTH(WIDTH)) ifa ();
  outbuf_deskew_if #(.WIDTH(WIDTH)) ifb ();
  outbuf_deskew #(.WIDTH(WIDTH), .DEPTH(8), .PADDING(3)) ua (.clk(clk), .rst(rst), .bus(ifa));
  outbuf_deskew #(.WIDTH(WIDTH), .DEPTH(8), .PADDING(0)) ub (.clk(clk), .rst(rst), .bus(ifb));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    ifa.start = 0; ifa.write = 0; ifa.read = 0; ifa.din = '0;
    ifb.start = 0; ifb.write = 0; ifb.read = 0; ifb.din = '0;
    repeat (2) step;
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      step;
      check("idle_dout", ifa.dout, 0);
      check("idle_empty", ifa.empty, 1);
      check("idle_full", ifa.full, 0);
      check("idle_dvalid", ifa.dvalid, 0);
      check("idle_b_empty", ifb.empty, 1);
    end
    ifa.write = 1;
    for (int i = 1; i <= 8; i++) begin
      ifa.din = word_t'(i);
      step;
    end
    ifa.write = 0;
    check("pad_notempty", ifa.empty, 0);
    check("pad_notfull", ifa.full, 0);
    ifa.read = 1;
    for (int i = 0; i < 5; i++) begin
      step;
      check("pad_dout", ifa.dout, 4 + i);
      check("pad_dvalid", ifa.dvalid, 1);
    end
    ifa.read = 0;
    check("pad_drained", ifa.empty, 1);
    step;
    check("pad_dvalid_low", ifa.dvalid, 0);
    check("pad_dout_hold", ifa.dout, 8);
    ifb.write = 1;
    for (int i = 0; i < 10; i++) begin
      ifb.din = word_t'(8'h10 + i);
      step;
      if (i == 6) check("ovf_not_full7", ifb.full, 0);
      if (i == 7) check("ovf_full8", ifb.full, 1);
    end
    ifb.write = 0;
    check("ovf_still_full", ifb.full, 1);
`ifdef OUTBUF_OVF_FLAG_EN
    check("ovf_flag_set", ifb.ovf, 1);
`endif
    ifb.read = 1;
    ifb.write = 1;
    for (int i = 0; i < 5; i++) begin
      ifb.din = word_t'(8'h20 + i);
      step;
      check("rw_full_dout", ifb.dout, 8'h10 + i);
      check("rw_full_full", ifb.full, 1);
    end
    ifb.write = 0;
    for (int i = 0; i < 8; i++) begin
      step;
      check("wrap_dout", ifb.dout, i < 3 ? 8'h15 + i : 8'h20 + i - 3);
    end
    ifb.read = 0;
    check("wrap_empty", ifb.empty, 1);
    ifb.read = 1;
    ifb.write = 1;
    ifb.din = 8'h55;
    step;
    ifb.read = 0;
    ifb.write = 0;
    check("rw_empty_dvalid", ifb.dvalid, 0);
    check("rw_empty_stored", ifb.empty, 0);
    check("rw_empty_hold", ifb.dout, 8'h24);
    ifb.read = 1;
    step;
    ifb.read = 0;
    check("rw_empty_later", ifb.dout, 8'h55);
    check("rw_empty_later_dv", ifb.dvalid, 1);
    check("rw_empty_after", ifb.empty, 1);
    ifb.start = 1;
    step;
    ifb.start = 0;
`ifdef OUTBUF_OVF_FLAG_EN
    check("ovf_cleared_start", ifb.ovf, 0);
`endif
    check("startb_empty", ifb.empty, 1);
    ifa.write = 1;
    ifa.din = 8'h31;
    step;
    ifa.din = 8'h32;
    step;
    ifa.write = 0;
    check("mid_stored", ifa.empty, 0);
    ifa.start = 1;
    ifa.write = 1;
    ifa.read = 1;
    ifa.din = 8'h99;
    step;
    ifa.start = 0;
    ifa.write = 0;
    ifa.read = 0;
    check("start_flush", ifa.empty, 1);
    check("start_dvalid", ifa.dvalid, 0);
    check("start_dout_hold", ifa.dout, 8);
    step;
    check("start_nowrite", ifa.empty, 1);
    ifa.write = 1;
    for (int i = 1; i <= 5; i++) begin
      ifa.din = word_t'(8'hA0 + i);
      step;
    end
    ifa.write = 0;
    check("rerun_notempty", ifa.empty, 0);
    ifa.read = 1;
    step;
    check("rerun_first", ifa.dout, 8'hA4);
    step;
    check("rerun_second", ifa.dout, 8'hA5);
    ifa.read = 0;
    check("rerun_empty", ifa.empty, 1);
    ifa.read = 1;
    step;
    ifa.read = 0;
    check("empty_read_dv", ifa.dvalid, 0);
    check("empty_read_hold", ifa.dout, 8'hA5);
    ifb.write = 1;
    ifb.din = 8'h77;
    step;
    step;
    ifb.write = 0;
    check("prerst_notempty", ifb.empty, 0);
    #2 rst = 1;
    #1;
    check("arst_empty", ifb.empty, 1);
    check("arst_dout", ifb.dout, 0);
    check("arst_full", ifb.full, 0);
    check("arst_a_dout", ifa.dout, 0);
    step;
    rst = 0;
    step;
    check("postrst_empty", ifb.empty, 1);
    ifb.read = 1;
    step;
    ifb.read = 0;
    check("postrst_dvalid", ifb.dvalid, 0);
    check("postrst_dout", ifb.dout, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
